wb_ps2_rx: RTL and testbench
============================

Name: wb_ps2_rx

Overview:
- Wishbone slave PS/2 keyboard/mouse receiver for the DE-1 board.
- Attaches to the free conbus slave slot at 0x7003xxxx, next to uart0/timer0/gpio0.
- Samples the device-driven PS/2 clock/data lines, deframes 11-bit frames, buffers scancodes in a FIFO.
- Raises an interrupt line for the LM32 intr_n vector.

Parameters:
- clk_freq, 50000000, system clock in Hz.
- fifo_adr_width, 4, log2 of FIFO depth (16 entries).
- filter_len, 8, consecutive equal samples required to accept a PS/2 line level.
- timeout_us, 2000, max gap between PS/2 clock falling edges inside a frame; timeout_cycles = clk_freq/1000000*timeout_us.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  Wishbone address; only [3:2] decoded.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte selects; ignored, all accesses treated as 32-bit.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  acknowledge.
- intr  out  1  active-high interrupt, level.
- ps2_clk  in  1  PS/2 clock from device, asynchronous.
- ps2_dat  in  1  PS/2 data from device, asynchronous.

Behaviour:
- Reset values (async, on reset_n low): wb_ack_o=0, wb_dat_o=0, intr=0, FIFO empty, sticky flags 0, CTRL=0x1, FSM=IDLE. Filtered lines reset to 1.
- Reset asserted mid-frame or mid-bus-cycle aborts everything immediately; no partial byte survives.
- Input path:
  - 2-flop synchronizer on each line, then filter.
  - Filter output changes only after filter_len identical consecutive synchronized samples.
  - Falling edge of filtered clock = sample strobe.
  - Latency from pin edge to strobe is 2+filter_len cycles.
- Frame FSM (advances only on sample strobe, only while CTRL.rx_en=1):
  - IDLE: dat=0 -> DATA with bitcnt=0. dat=1 -> stay IDLE (spurious start ignored, no flag).
  - DATA: shift in LSB first. After 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP:
    - Odd parity wrong -> set PERR, drop byte.
    - Else stop bit 0 -> set FERR, drop byte.
    - Else push byte.
    - In all cases -> IDLE.
- Timeout:
  - Counter clears on every strobe.
  - In any state other than IDLE, reaching timeout_cycles -> IDLE and set FERR.
- Disable: CTRL.rx_en=0 forces FSM to IDLE the next cycle and ignores strobes. FIFO contents are retained.
- FIFO:
  - Push occurs the cycle after the STOP strobe; byte is readable from the following cycle.
  - Push while full and no pop in the same cycle -> byte dropped, set OVR.
  - Simultaneous push and pop, including when full -> both occur, count unchanged, no OVR.
  - Pointers wrap modulo 2^fifo_adr_width.
  - count is fifo_adr_width+1 bits wide.
- Register map (wb_adr_i[3:2]):
  - 0 RXDATA, read: [7:0]=head byte, [8]=valid (FIFO non-empty), rest 0. Read pops only if valid. Read when empty returns 0 with no side effect. Writes ignored.
  - 1 STATUS, read: [0]=not_empty, [1]=full, [2]=OVR, [3]=PERR, [4]=FERR, [12:8]=count (zero-extended). Write: 1 in bits [4:2] clears the corresponding flag (W1C).
  - Simultaneous W1C and new flag event in the same cycle -> flag stays set.
  - 2 CTRL, R/W: [0]=rx_en, [1]=irq_en, rest read 0.
  - 3 reserved: reads 0, writes ignored.
- Wishbone handshake:
  - wb_ack_o asserts for exactly one cycle, the cycle after wb_stb_i&wb_cyc_i&~wb_ack_o is seen.
  - wb_dat_o is registered and valid with ack.
  - Side effects (pop, W1C, CTRL write) happen on the ack cycle, exactly once per access.
  - No ack without cyc&stb. Zero-wait-state back-to-back requests are acked every other cycle.
- Interrupt: intr registered = CTRL.irq_en & (not_empty | OVR | PERR | FERR). Asserts 1 cycle after the causing condition.

Test Plan:
- Reset then read CTRL/STATUS/RXDATA -> 0x1, 0x0, 0x0; wb_ack_o one cycle per access; intr=0.
- Frame for 0x1C (start 0, data LSB first 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz -> STATUS=0x101, RXDATA=0x11C, second RXDATA read=0x000, STATUS=0x000.
- Frame 0x1C with parity 1 -> PERR set (STATUS=0x008), FIFO empty. Write STATUS 0x008 -> STATUS=0x000.
- 17 valid frames 0x00..0x10 with no reads -> STATUS=0x1007 (count16, full, OVR, not_empty). Reads return 0x100..0x10F in order; 0x10 lost.
- Stop after 5 data bits for >2 ms -> FERR set, FSM idle. A following valid frame 0xF0 is received correctly as 0x1F0.
- CTRL=0x3, then one valid frame -> intr rises 1 cycle after push; one RXDATA read -> intr drops the cycle after the ack. 50 ns glitch on ps2_clk -> no bit sampled.

Source files
------------

// File: rtl/wb_ps2_rx.sv
// wb_ps2_rx: Wishbone slave PS/2 receiver; filters the device lines, deframes 11-bit frames into a FIFO and raises a level interrupt.
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   wb_adr_i .. wb_ack_o Wishbone slave; registers selected by wb_adr_i[3:2]
//                        (0 RXDATA, 1 STATUS, 2 CTRL, 3 reserved)
//   intr                 active-high level interrupt
//   ps2_clk, ps2_dat     asynchronous PS/2 lines driven by the device
module wb_ps2_rx #(
  parameter int clk_freq       = 50000000,
  parameter int fifo_adr_width = 4,
  parameter int filter_len     = 8,
  parameter int timeout_us     = 2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        ps2_clk,
  input  logic        ps2_dat
);
  localparam int AW  = fifo_adr_width;
  localparam int TOC = clk_freq / 1000000 * timeout_us;
  localparam int TW  = $clog2(TOC + 1);
  localparam int FW  = $clog2(filter_len + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0] pins, s1_q, s2_q, flt_q;
  logic [FW-1:0] fcnt_q [2];
  logic cprev_q, strobe, dat;
  state_t state_q;
  logic [2:0] bitcnt_q;
  logic [7:0] sh_q;
  logic par_q, push_q, perr_ev_q, ferr_ev_q;
  logic [TW-1:0] tcnt_q;
  logic [7:0] mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic [1:0] ctrl_q;
  logic ack_q, ovr_q, perr_q, ferr_q, intr_q;
  logic [31:0] dat_q, rdata, status;
  logic req, ne, full, pop, wr, ovr_ev;
  logic [2:0] clr;
  logic unused;
  assign unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:5]};
  assign pins = {ps2_dat, ps2_clk};
  // A line level is accepted only after filter_len consecutive samples disagree with the current one.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_q <= '1;
      s2_q <= '1;
      flt_q <= '1;
      cprev_q <= 1'b1;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
    end else begin
      s1_q <= pins;
      s2_q <= s1_q;
      cprev_q <= flt_q[0];
      for (int k = 0; k < 2; k++)
        if (s2_q[k] == flt_q[k]) fcnt_q[k] <= '0;
        else if (fcnt_q[k] == FW'(filter_len - 1)) begin
          flt_q[k] <= s2_q[k];
          fcnt_q[k] <= '0;
        end else fcnt_q[k] <= fcnt_q[k] + 1'b1;
    end
  assign strobe = cprev_q & ~flt_q[0];
  assign dat = flt_q[1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      bitcnt_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      tcnt_q <= '0;
      push_q <= 1'b0;
      perr_ev_q <= 1'b0;
      ferr_ev_q <= 1'b0;
    end else begin
      push_q <= 1'b0;
      perr_ev_q <= 1'b0;
      ferr_ev_q <= 1'b0;
      if (!ctrl_q[0]) begin
        state_q <= IDLE;
        tcnt_q <= '0;
      end else if (strobe) begin
        tcnt_q <= '0;
        case (state_q)
          IDLE: if (!dat) begin
            state_q <= DATA;
            bitcnt_q <= '0;
          end
          DATA: begin
            sh_q <= {dat, sh_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q <= dat;
            state_q <= STOP;
          end
          default: begin
            perr_ev_q <= ~^{sh_q, par_q};
            ferr_ev_q <= ^{sh_q, par_q} & ~dat;
            push_q <= ^{sh_q, par_q} & dat;
            state_q <= IDLE;
          end
        endcase
      end else if (state_q != IDLE) begin
        if (tcnt_q == TW'(TOC - 1)) begin
          state_q <= IDLE;
          ferr_ev_q <= 1'b1;
          tcnt_q <= '0;
        end else tcnt_q <= tcnt_q + 1'b1;
      end
    end
  assign req = wb_stb_i & wb_cyc_i & ~ack_q;
  assign ne = count_q != '0;
  assign full = count_q[AW];
  assign pop = req & ~wb_we_i & (wb_adr_i[3:2] == 2'd0) & ne;
  assign clr = (req & wb_we_i & (wb_adr_i[3:2] == 2'd1)) ? wb_dat_i[4:2] : 3'b0;
  // A full FIFO still accepts the byte when a pop happens on the same edge.
  assign wr = push_q & (~full | pop);
  assign ovr_ev = push_q & full & ~pop;
  assign status = {{(23 - AW){1'b0}}, count_q, 3'b0, ferr_q, perr_q, ovr_q, full, ne};
  assign rdata = (wb_adr_i[3:2] == 2'd0) ? (ne ? {23'b0, 1'b1, mem_q[rd_ptr_q]} : 32'b0)
               : (wb_adr_i[3:2] == 2'd1) ? status
               : (wb_adr_i[3:2] == 2'd2) ? {30'b0, ctrl_q} : 32'b0;
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= sh_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      ctrl_q <= 2'b01;
      ovr_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      intr_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rdata;
      if (req & wb_we_i & (wb_adr_i[3:2] == 2'd2)) ctrl_q <= wb_dat_i[1:0];
      ovr_q <= ovr_ev | (ovr_q & ~clr[0]);
      perr_q <= perr_ev_q | (perr_q & ~clr[1]);
      ferr_q <= ferr_ev_q | (ferr_q & ~clr[2]);
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW + 1)'(wr) - (AW + 1)'(pop);
      intr_q <= ctrl_q[1] & (ne | ovr_q | perr_q | ferr_q);
    end
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr = intr_q;
endmodule

// File: tb/tb_wb_ps2_rx.sv
// tb_wb_ps2_rx: directed bench for wb_ps2_rx; PS/2 frames with hand-computed register values.
module tb_wb_ps2_rx;
  localparam int H = 40;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic [3:0] sel = 4'hf;
  logic stb = 1'b0;
  logic cyc = 1'b0;
  logic we = 1'b0;
  logic ack, intr;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  logic intr_at_ack = 1'b0;
  int checks = 0;
  int failures = 0;
  always #10 clk = ~clk;
  wb_ps2_rx #(.clk_freq(1000000), .fifo_adr_width(4), .filter_len(8), .timeout_us(300)) dut (
    .clk(clk), .reset_n(reset_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
    .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_we_i(we), .wb_ack_o(ack),
    .intr(intr), .ps2_clk(ps2c), .ps2_dat(ps2d)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] q);
    int n = 0;
    adr = 32'h7003_0000 | {28'b0, a, 2'b00};
    wdat = d;
    we = w;
    stb = 1'b1;
    cyc = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ack !== 1'b1 && n < 8);
    chk("ack_seen", 32'(ack), 32'd1);
    chk("ack_latency", n, 1);
    q = rdat;
    intr_at_ack = intr;
    stb = 1'b0;
    cyc = 1'b0;
    we = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_single", 32'(ack), 32'd0);
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] q;
    wb(1'b0, a, 32'd0, q);
    chk(tag, q, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb(1'b1, a, d, q);
  endtask
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = f[i];
      repeat (H) @(negedge clk);
      ps2c = 1'b0;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bits({1'b1, (~^b) ^ bad, b, 1'b0}, 11);
    repeat (H) @(negedge clk);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    repeat (4) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_ack", 32'(ack), 32'd0);
    rd(2'd2, 32'h1, "rst_ctrl");
    rd(2'd1, 32'h0, "rst_status");
    rd(2'd0, 32'h0, "rst_rxdata");
    rd(2'd3, 32'h0, "reserved");
    send_frame(8'h1c, 1'b0);
    chk("intr_masked", 32'(intr), 32'd0);
    rd(2'd1, 32'h101, "f1c_status");
    rd(2'd0, 32'h11c, "f1c_rx");
    rd(2'd0, 32'h000, "f1c_rx_empty");
    rd(2'd1, 32'h000, "f1c_status_empty");
    send_frame(8'h1c, 1'b1);
    rd(2'd1, 32'h008, "perr_status");
    wr(2'd1, 32'h008);
    rd(2'd1, 32'h000, "perr_cleared");
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0);
    rd(2'd1, 32'h1007, "full_status");
    for (int i = 0; i < 16; i++) rd(2'd0, 32'h100 + 32'(i), "full_drain");
    rd(2'd0, 32'h000, "drain_empty");
    rd(2'd1, 32'h004, "ovr_sticky");
    wr(2'd1, 32'h004);
    rd(2'd1, 32'h000, "ovr_cleared");
    send_bits({1'b1, 1'b1, 8'hff, 1'b0}, 6);
    rd(2'd1, 32'h000, "before_timeout");
    repeat (400) @(negedge clk);
    rd(2'd1, 32'h010, "ferr_timeout");
    wr(2'd1, 32'h01c);
    rd(2'd1, 32'h000, "ferr_cleared");
    send_frame(8'hf0, 1'b0);
    rd(2'd0, 32'h1f0, "after_timeout_rx");
    wr(2'd2, 32'h3);
    rd(2'd2, 32'h3, "ctrl_rw");
    chk("intr_idle", 32'(intr), 32'd0);
    send_frame(8'h5a, 1'b0);
    chk("intr_rise", 32'(intr), 32'd1);
    rd(2'd0, 32'h15a, "irq_rx");
    chk("intr_at_ack", 32'(intr_at_ack), 32'd1);
    chk("intr_drop", 32'(intr), 32'd0);
    ps2d = 1'b0;
    @(negedge clk);
    ps2c = 1'b0;
    #50;
    ps2c = 1'b1;
    @(negedge clk);
    ps2d = 1'b1;
    repeat (400) @(negedge clk);
    rd(2'd1, 32'h000, "glitch_status");
    chk("glitch_intr", 32'(intr), 32'd0);
    send_frame(8'h77, 1'b0);
    wr(2'd2, 32'h2);
    send_frame(8'h33, 1'b0);
    rd(2'd1, 32'h101, "disabled_retain");
    rd(2'd0, 32'h177, "disabled_rx");
    rd(2'd1, 32'h000, "disabled_empty");
    wr(2'd2, 32'h1);
    send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 5);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_intr", 32'(intr), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd1, 32'h000, "midrst_status");
    rd(2'd2, 32'h1, "midrst_ctrl");
    send_frame(8'ha5, 1'b0);
    rd(2'd0, 32'h1a5, "midrst_rx");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
